// File: rtl/map_ram_arbiter.sv
// Single-port map RAM arbiter: sprite writer (with RMW lock) beats renderer and
// collision readers; readers alternate; read returns are routed by owner pipeline.
module map_ram_arbiter #(
  parameter int RD_LAT   = 2,
  parameter int LOCK_MAX = 16
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         wr_req,
  input  logic         wr_we,
  input  logic         wr_lock,
  input  logic [4:0]   wr_addr,
  input  logic [159:0] wr_data,
  input  logic         vga_req,
  input  logic [4:0]   vga_addr,
  input  logic         col_req,
  input  logic [4:0]   col_addr,
  output logic         wr_gnt,
  output logic         vga_gnt,
  output logic         col_gnt,
  output logic         wr_rvalid,
  output logic         vga_rvalid,
  output logic         col_rvalid,
  output logic [159:0] rdata,
  output logic [4:0]   ram_addr,
  output logic         ram_wren,
  output logic [159:0] ram_wrdata,
  input  logic [159:0] ram_q,
  output logic         lock_err
);

  // state   | meaning
  // ST_OPEN | normal arbitration, readers may be granted
  // ST_LOCK | writer holds the RAM for read-modify-write, readers blocked
  typedef enum logic {ST_OPEN, ST_LOCK} lock_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_WR, OWN_VGA, OWN_COL} owner_t;

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  lock_state_t      state, state_nxt;
  logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
  logic             lock_err_nxt;
  logic             rr_col, rr_col_nxt;
  owner_t           owner_pipe [RD_LAT];
  owner_t           issue_owner;
  owner_t           ret_owner;

  // Grants are gated by reset so the RAM port is quiet the instant reset rises.
  always_comb begin
    wr_gnt      = 1'b0;
    vga_gnt     = 1'b0;
    col_gnt     = 1'b0;
    ram_addr    = '0;
    ram_wren    = 1'b0;
    ram_wrdata  = '0;
    issue_owner = OWN_NONE;
    if (!reset) begin
      if (wr_req) begin
        wr_gnt   = 1'b1;
        ram_addr = wr_addr;
        ram_wren = wr_we;
        if (wr_we) ram_wrdata = wr_data;
        else       issue_owner = OWN_WR;
      end else if (state == ST_OPEN) begin
        if (vga_req && (!col_req || !rr_col)) begin
          vga_gnt     = 1'b1;
          ram_addr    = vga_addr;
          issue_owner = OWN_VGA;
        end else if (col_req) begin
          col_gnt     = 1'b1;
          ram_addr    = col_addr;
          issue_owner = OWN_COL;
        end
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = '0;
    lock_err_nxt = lock_err;
    rr_col_nxt   = rr_col;
    if (vga_gnt)      rr_col_nxt = 1'b1;
    else if (col_gnt) rr_col_nxt = 1'b0;
    case (state)
      ST_OPEN: if (wr_gnt && wr_lock) state_nxt = ST_LOCK;
      ST_LOCK: begin
        if (!wr_lock) begin
          state_nxt = ST_OPEN;
        end else if (lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
          // this is the LOCK_MAX-th locked cycle: break the lock
          state_nxt    = ST_OPEN;
          lock_err_nxt = 1'b1;
        end else begin
          lock_cnt_nxt = lock_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_OPEN;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state    <= ST_OPEN;
      lock_cnt <= '0;
      lock_err <= 1'b0;
      rr_col   <= 1'b0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
      lock_err <= lock_err_nxt;
      rr_col   <= rr_col_nxt;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) owner_pipe[i] <= OWN_NONE;
    end else begin
      owner_pipe[0] <= issue_owner;
      for (int i = 1; i < RD_LAT; i++) owner_pipe[i] <= owner_pipe[i-1];
    end
  end

  assign ret_owner  = owner_pipe[RD_LAT-1];
  assign wr_rvalid  = (ret_owner == OWN_WR);
  assign vga_rvalid = (ret_owner == OWN_VGA);
  assign col_rvalid = (ret_owner == OWN_COL);
  assign rdata      = (ret_owner != OWN_NONE) ? ram_q : '0;

endmodule

// File: tb/tb_map_ram_arbiter.sv
// Bench for map_ram_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based transaction model.
module tb_map_ram_arbiter;
  localparam int RD_LAT   = 2;
  localparam int LOCK_MAX = 16;

  logic         CLOCK_50 = 1'b0;
  logic         reset = 1'b0;
  logic         wr_req = 0, wr_we = 0, wr_lock = 0;
  logic [4:0]   wr_addr = '0;
  logic [159:0] wr_data = '0;
  logic         vga_req = 0, col_req = 0;
  logic [4:0]   vga_addr = '0, col_addr = '0;
  logic         wr_gnt, vga_gnt, col_gnt;
  logic         wr_rvalid, vga_rvalid, col_rvalid;
  logic [159:0] rdata;
  logic [4:0]   ram_addr;
  logic         ram_wren;
  logic [159:0] ram_wrdata;
  logic [159:0] ram_q = '0;
  logic         lock_err;

  int checks = 0;
  int passed = 0;

  map_ram_arbiter #(.RD_LAT(RD_LAT), .LOCK_MAX(LOCK_MAX)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .wr_req(wr_req), .wr_we(wr_we), .wr_lock(wr_lock), .wr_addr(wr_addr), .wr_data(wr_data),
    .vga_req(vga_req), .vga_addr(vga_addr), .col_req(col_req), .col_addr(col_addr),
    .wr_gnt(wr_gnt), .vga_gnt(vga_gnt), .col_gnt(col_gnt),
    .wr_rvalid(wr_rvalid), .vga_rvalid(vga_rvalid), .col_rvalid(col_rvalid),
    .rdata(rdata), .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wrdata(ram_wrdata),
    .ram_q(ram_q), .lock_err(lock_err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Transaction model: pending read returns as (due cycle, requester) records.
  typedef struct { int due; int who; } ret_t;
  ret_t         m_rq[$];
  bit           m_rr_col, m_lock, m_err;
  int           m_cnt, m_cyc;
  bit           e_wr, e_vga, e_col, e_wren;
  logic [4:0]   e_addr;
  logic [159:0] e_wrdata, e_rdata;
  int           e_ret;

  function automatic logic [159:0] rand160();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function void model_reset();
    m_rq.delete();
    m_rr_col = 0; m_lock = 0; m_err = 0; m_cnt = 0; m_cyc = 0;
  endfunction

  function void model_eval();
    e_wr   = wr_req;
    e_vga  = !wr_req && !m_lock && vga_req && (!col_req || !m_rr_col);
    e_col  = !wr_req && !m_lock && col_req && !e_vga;
    e_wren = e_wr && wr_we;
    e_addr = e_wr ? wr_addr : e_vga ? vga_addr : e_col ? col_addr : 5'd0;
    e_wrdata = e_wren ? wr_data : '0;
    e_ret  = (m_rq.size() > 0 && m_rq[0].due == m_cyc) ? m_rq[0].who : 0;
    e_rdata = (e_ret != 0) ? ram_q : '0;
  endfunction

  function void model_commit();
    if (e_ret != 0) void'(m_rq.pop_front());
    if (e_wr && !wr_we) m_rq.push_back('{m_cyc + RD_LAT, 1});
    if (e_vga) m_rq.push_back('{m_cyc + RD_LAT, 2});
    if (e_col) m_rq.push_back('{m_cyc + RD_LAT, 3});
    if (e_vga) m_rr_col = 1;
    else if (e_col) m_rr_col = 0;
    if (m_lock) begin
      if (!wr_lock) begin
        m_lock = 0; m_cnt = 0;
      end else begin
        m_cnt++;
        if (m_cnt >= LOCK_MAX) begin m_err = 1; m_lock = 0; m_cnt = 0; end
      end
    end else if (e_wr && wr_lock) begin
      m_lock = 1;
    end
    m_cyc++;
  endfunction

  function automatic logic [12:0] obs_ctl();
    return {wr_gnt, vga_gnt, col_gnt, wr_rvalid, vga_rvalid, col_rvalid, ram_wren, lock_err, ram_addr};
  endfunction

  function automatic logic [12:0] exp_ctl();
    return {e_wr, e_vga, e_col, e_ret == 1, e_ret == 2, e_ret == 3, e_wren, m_err, e_addr};
  endfunction

  task automatic cycle_begin();
    @(posedge CLOCK_50);
    #1;
    ram_q = rand160();
  endtask

  task automatic cycle_sample();
    @(negedge CLOCK_50);
    model_eval();
  endtask

  task automatic idle_inputs();
    wr_req = 0; wr_we = 0; wr_lock = 0; vga_req = 0; col_req = 0;
  endtask

  task automatic test_reset();
    wr_req = 1; wr_we = 1; vga_req = 1; col_req = 1;
    wr_addr = 5'd17; vga_addr = 5'd3; col_addr = 5'd7; wr_data = rand160(); ram_q = rand160();
    #1 reset = 1;
    #1;
    checks++;
    if (obs_ctl() !== 13'd0) $display("FAIL reset ctl: got %h want 0", obs_ctl()); else passed++;
    checks++;
    if (rdata !== '0) $display("FAIL reset rdata: got %h want 0", rdata); else passed++;
    checks++;
    if (ram_wrdata !== '0) $display("FAIL reset wrdata: got %h want 0", ram_wrdata); else passed++;
    idle_inputs();
    @(negedge CLOCK_50);
    reset = 0;
    model_reset();
  endtask

  task automatic test_round_robin();
    for (int c = 0; c < 7; c++) begin
      cycle_begin();
      idle_inputs();
      vga_req = (c < 4); col_req = (c < 4); vga_addr = 5'd3; col_addr = 5'd7;
      cycle_sample();
      if (c < 4) begin
        checks++;
        if ({vga_gnt, col_gnt} !== ((c % 2 == 0) ? 2'b10 : 2'b01))
          $display("FAIL rr order c%0d: got %b want %b", c, {vga_gnt, col_gnt}, (c % 2 == 0) ? 2'b10 : 2'b01);
        else passed++;
      end
      checks++;
      if (obs_ctl() !== exp_ctl()) $display("FAIL rr ctl c%0d: got %h want %h", c, obs_ctl(), exp_ctl()); else passed++;
      checks++;
      if (rdata !== e_rdata) $display("FAIL rr rdata c%0d: got %h want %h", c, rdata, e_rdata); else passed++;
      model_commit();
    end
  endtask

  task automatic test_wr_priority();
    logic [2:0] want;
    for (int c = 0; c < 7; c++) begin
      cycle_begin();
      idle_inputs();
      wr_req = (c == 0); wr_addr = 5'd9;
      vga_req = (c <= 1); vga_addr = 5'd4;
      col_req = (c == 1 || c == 2); col_addr = 5'd12;
      cycle_sample();
      want = (c == 0) ? 3'b100 : (c == 1) ? 3'b010 : (c == 2) ? 3'b001 : 3'b000;
      checks++;
      if ({wr_gnt, vga_gnt, col_gnt} !== want)
        $display("FAIL prio gnt c%0d: got %b want %b", c, {wr_gnt, vga_gnt, col_gnt}, want);
      else passed++;
      checks++;
      if (obs_ctl() !== exp_ctl()) $display("FAIL prio ctl c%0d: got %h want %h", c, obs_ctl(), exp_ctl()); else passed++;
      checks++;
      if (rdata !== e_rdata) $display("FAIL prio rdata c%0d: got %h want %h", c, rdata, e_rdata); else passed++;
      model_commit();
    end
  endtask

  task automatic test_lock_write();
    logic [159:0] x;
    logic [2:0]   want;
    x = rand160();
    for (int c = 0; c < 8; c++) begin
      cycle_begin();
      idle_inputs();
      wr_req = (c <= 1); wr_lock = (c <= 1); wr_we = (c == 1); wr_addr = 5'd5; wr_data = x;
      vga_req = (c <= 3); vga_addr = 5'd2;
      cycle_sample();
      want = {c == 3, c == 1, c == 2};
      checks++;
      if ({vga_gnt, ram_wren, wr_rvalid} !== want)
        $display("FAIL lockwr vga/wren/rvalid c%0d: got %b want %b", c, {vga_gnt, ram_wren, wr_rvalid}, want);
      else passed++;
      checks++;
      if (obs_ctl() !== exp_ctl()) $display("FAIL lockwr ctl c%0d: got %h want %h", c, obs_ctl(), exp_ctl()); else passed++;
      checks++;
      if (ram_wrdata !== e_wrdata) $display("FAIL lockwr wrdata c%0d: got %h want %h", c, ram_wrdata, e_wrdata); else passed++;
      checks++;
      if (rdata !== e_rdata) $display("FAIL lockwr rdata c%0d: got %h want %h", c, rdata, e_rdata); else passed++;
      model_commit();
    end
  endtask

  task automatic test_lock_timeout();
    logic [1:0] want;
    for (int c = 0; c < LOCK_MAX + 9; c++) begin
      cycle_begin();
      idle_inputs();
      wr_req = (c == 0); wr_addr = 5'd1; wr_lock = (c <= 20);
      col_req = (c <= LOCK_MAX + 1); col_addr = 5'd6;
      cycle_sample();
      want = {c == LOCK_MAX + 1, c >= LOCK_MAX + 1};
      checks++;
      if ({col_gnt, lock_err} !== want)
        $display("FAIL timeout col_gnt/lock_err c%0d: got %b want %b", c, {col_gnt, lock_err}, want);
      else passed++;
      checks++;
      if (obs_ctl() !== exp_ctl()) $display("FAIL timeout ctl c%0d: got %h want %h", c, obs_ctl(), exp_ctl()); else passed++;
      checks++;
      if (rdata !== e_rdata) $display("FAIL timeout rdata c%0d: got %h want %h", c, rdata, e_rdata); else passed++;
      model_commit();
    end
  endtask

  task automatic test_reset_inflight();
    cycle_begin();
    idle_inputs();
    vga_req = 1; vga_addr = 5'd8;
    cycle_sample();
    checks++;
    if (vga_gnt !== 1'b1) $display("FAIL inflight grant: got %b want 1", vga_gnt); else passed++;
    model_commit();
    cycle_begin();
    reset = 1;
    #1;
    checks++;
    if (obs_ctl() !== 13'd0) $display("FAIL inflight reset ctl: got %h want 0", obs_ctl()); else passed++;
    checks++;
    if ({rdata, ram_wrdata} !== '0) $display("FAIL inflight reset data: got %h want 0", {rdata, ram_wrdata}); else passed++;
    idle_inputs();
    model_reset();
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 0;
    for (int c = 0; c < 5; c++) begin
      cycle_begin();
      cycle_sample();
      checks++;
      if ({vga_rvalid, lock_err} !== 2'b00)
        $display("FAIL inflight stale c%0d: got %b want 00", c, {vga_rvalid, lock_err});
      else passed++;
      checks++;
      if (obs_ctl() !== exp_ctl()) $display("FAIL inflight ctl c%0d: got %h want %h", c, obs_ctl(), exp_ctl()); else passed++;
      model_commit();
    end
  endtask

  task automatic test_random();
    bit wr_p = 0, vga_p = 0, col_p = 0;
    for (int c = 0; c < 400; c++) begin
      cycle_begin();
      if (!wr_p) begin
        wr_lock = m_lock ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 3) == 0);
        wr_req  = ($urandom_range(0, 99) < 25);
        wr_we   = 1'($urandom);
        wr_addr = 5'($urandom);
        wr_data = rand160();
        wr_p    = wr_req;
      end
      if (!vga_p) begin
        vga_req = ($urandom_range(0, 99) < 50); vga_addr = 5'($urandom); vga_p = vga_req;
      end
      if (!col_p) begin
        col_req = ($urandom_range(0, 99) < 50); col_addr = 5'($urandom); col_p = col_req;
      end
      cycle_sample();
      checks++;
      if (obs_ctl() !== exp_ctl()) $display("FAIL rand ctl c%0d: got %h want %h", c, obs_ctl(), exp_ctl()); else passed++;
      checks++;
      if (rdata !== e_rdata) $display("FAIL rand rdata c%0d: got %h want %h", c, rdata, e_rdata); else passed++;
      checks++;
      if (ram_wrdata !== e_wrdata) $display("FAIL rand wrdata c%0d: got %h want %h", c, ram_wrdata, e_wrdata); else passed++;
      if (e_wr)  wr_p = 0;
      if (e_vga) vga_p = 0;
      if (e_col) col_p = 0;
      model_commit();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_wr_priority();
    test_lock_write();
    test_lock_timeout();
    test_reset_inflight();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/map_ram_arbiter.md
MAP_RAM_ARBITER -- requirements
Module: map_ram_arbiter

Interface
REQ-001 Parameter RD_LAT, default 2, is the map RAM read latency in cycles from address presentation to valid q.
REQ-002 Parameter LOCK_MAX, default 16, is the maximum number of consecutive cycles the writer lock may be held.
REQ-003 CLOCK_50  input  1  is the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  is the reset, asynchronous and active-high.
REQ-005 wr_req / wr_we / wr_lock  input  1/1/1  are the sprite writer's access request, write enable and read-modify-write lock.
REQ-006 wr_addr / wr_data  input  5/160  are the writer's row address and write data.
REQ-007 vga_req / vga_addr  input  1/5  are the renderer's read request and row address.
REQ-008 col_req / col_addr  input  1/5  are the collision detector's read request and row address.
REQ-009 wr_gnt / vga_gnt / col_gnt  output  1/1/1  are per-requester, one-cycle accept strobes.
REQ-010 wr_rvalid / vga_rvalid / col_rvalid  output  1/1/1  are per-requester read-return strobes.
REQ-011 rdata  output  160  is the shared read-return data, valid only when some rvalid is high.
REQ-012 ram_addr / ram_wren / ram_wrdata  output  5/1/160  drive the single shared map RAM port.
REQ-013 ram_q  input  160  is the RAM read data.
REQ-014 lock_err  output  1  is a sticky lock-timeout flag.

Function
REQ-015 The block SHALL accept at most one access per cycle; exactly one gnt or none is high each cycle.
REQ-016 Grants SHALL be combinational from the current req inputs and registered arbiter state; ram_addr, ram_wren and ram_wrdata SHALL be driven in the same cycle as the grant.
REQ-017 When no grant is given: ram_wren=0, ram_addr=0, ram_wrdata=0.
REQ-018 Priority: the writer wins over both readers whenever wr_req=1.
REQ-019 Between vga and col, a 1-bit round-robin pointer SHALL select; the pointer flips to the other reader after each reader grant and is unchanged by writer grants or idle cycles.
REQ-020 A granted access with wr_we=1 SHALL assert ram_wren=1 with ram_wrdata=wr_data; it produces no rvalid.
REQ-021 Every granted read SHALL produce exactly one rvalid on the same requester exactly RD_LAT cycles after its grant, with rdata=ram_q in that cycle, tracked by an RD_LAT-deep owner shift register; when no rvalid is high, rdata=0.
REQ-022 Back-to-back reads from any mix of requesters SHALL be pipelined, one per cycle, with returns in grant order.
REQ-023 Lock state SHALL be entered on a writer grant with wr_lock=1 and left when wr_lock=0.
REQ-024 While in lock state, vga_gnt and col_gnt SHALL be 0 even if wr_req=0.
REQ-025 A lock counter SHALL count cycles in lock state, saturating at LOCK_MAX; on reaching LOCK_MAX the block SHALL set lock_err=1, force lock state off, and resume normal arbitration the next cycle.
REQ-026 lock_err SHALL clear only on reset.
REQ-027 The counter SHALL clear on every lock exit.
REQ-028 Requests asserted and withdrawn before being granted SHALL be dropped with no side effects; requesters hold req and addr until gnt.

Reset
REQ-029 On reset assertion, without waiting for a clock edge, all gnt, rvalid, ram_wren and lock_err outputs SHALL be 0, ram_addr and ram_wrdata SHALL be 0, and rdata SHALL be 0.
REQ-030 Reset SHALL clear the owner pipeline, the lock state and the lock counter, and set the round-robin pointer to vga.
REQ-031 Reads in flight at reset SHALL be discarded: no rvalid is issued for them after reset release.

Verification
REQ-032 Scenario: vga_req=1 addr=3 and col_req=1 addr=7 held for 4 cycles -> grants vga, col, vga, col; rvalids follow 2 cycles after each grant, each carrying that cycle's ram_q.
REQ-033 Scenario: wr_req=1, wr_lock=1, wr_we=0, addr=5, then wr_we=1, data=X, then lock released, with vga_req held high throughout -> vga_gnt=0 until the cycle after wr_lock falls; ram_wren=1 only in the write cycle; wr_rvalid=1 two cycles after the read grant.
REQ-034 Scenario: wr_req and vga_req both rise in the same cycle -> wr_gnt first and vga_gnt next cycle; the pointer is unchanged by the writer grant.
REQ-035 Scenario: wr_lock held high for 20 cycles after a writer grant, with col_req high -> lock_err rises when LOCK_MAX=16 is reached, col_gnt follows next cycle, and lock_err stays 1 until reset.
REQ-036 Scenario: reset asserted one cycle after a vga read grant -> outputs go 0 immediately and no vga_rvalid occurs after reset release.
